// File: rtl/bcd_field_scheduler_pkg.sv
// clk_disp_pkg: shared constants and enums for the clock/calendar display path
package clk_disp_pkg;
  localparam int NUM_FIELDS = 7;
  localparam int DIV_ITERS = 7;
  localparam int FIELD_W = 7;
  localparam logic [7:0] SAT_BCD = 8'h99;
  typedef enum logic [2:0] {F_SEC, F_MIN, F_HRS, F_DAY, F_MON, F_YEAR, F_CEN} field_e;
  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_DIV, S_STORE, S_DONE} state_e;
endpackage

// File: rtl/bcd_field_scheduler_if.sv
// bcd_field_scheduler_if: counter inputs, refresh request and published digit bus
interface bcd_field_scheduler_if;
  logic tick_i;
  logic [5:0] sec_ctr, min_ctr;
  logic [4:0] hrs_ctr, day_o;
  logic [3:0] month_o;
  logic [6:0] year_o, cen_o;
  logic [55:0] bcd_o;
  logic busy_o, done_o, range_err_o;
  modport master (
    output tick_i, sec_ctr, min_ctr, hrs_ctr, day_o, month_o, year_o, cen_o,
    input bcd_o, busy_o, done_o, range_err_o
  );
  modport slave (
    input tick_i, sec_ctr, min_ctr, hrs_ctr, day_o, month_o, year_o, cen_o,
    output bcd_o, busy_o, done_o, range_err_o
  );
endinterface

// File: rtl/bcd_field_scheduler_div10_seq.sv
// div10_seq: restoring divide-by-10, one quotient bit per cycle, ready one cycle after the last bit
module div10_seq
  import clk_disp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [FIELD_W-1:0] dividend,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic ready
);
  logic [FIELD_W-1:0] dq;
  logic [3:0] rem;
  logic [2:0] cnt;
  logic run;
  logic [4:0] trial;
  logic fit;
  // trial subtraction: bring down the next dividend bit and test against 10
  always_comb begin
    trial = {rem, dq[FIELD_W-1]};
    fit = trial >= 5'd10;
  end
  // dq shifts dividend bits out and quotient bits in; rem holds the partial remainder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq <= '0;
      rem <= '0;
      cnt <= '0;
      run <= 1'b0;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (start) begin
        dq <= dividend;
        rem <= '0;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        rem <= fit ? 4'(trial - 5'd10) : trial[3:0];
        dq <= {dq[FIELD_W-2:0], fit};
        cnt <= cnt + 3'd1;
        if (cnt == 3'(DIV_ITERS - 1)) begin
          run <= 1'b0;
          ready <= 1'b1;
        end
      end
    end
  end
  assign quotient = dq[3:0];
  assign remainder = rem;
endmodule

// File: rtl/bcd_field_scheduler.sv
// bcd_field_scheduler: time-shares one divide-by-10 across seven fields and publishes 14 BCD digits atomically
module bcd_field_scheduler
  import clk_disp_pkg::*;
#(
  parameter bit AUTO_SCAN = 1'b0
) (
  input logic clk,
  input logic rst_n,
  bcd_field_scheduler_if.slave bus
);
  state_e state, nxt;
  logic pend;
  logic [2:0] fld, iter, idx;
  logic [FIELD_W-1:0] snap [NUM_FIELDS];
  logic [47:0] shd;
  logic err_sh;
  logic [55:0] bcd;
  logic rerr;
  logic start, rdy, ovf, wr, last;
  logic [3:0] q, r;
  logic [7:0] st_byte;
  div10_seq u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(snap[idx]),
    .quotient(q),
    .remainder(r),
    .ready(rdy)
  );
  // next state plus divider launch and saturating store byte
  always_comb begin
    nxt = state;
    last = fld == F_CEN;
    unique case (state)
      S_IDLE: nxt = bus.tick_i ? S_SNAP : S_IDLE;
      S_SNAP: nxt = S_DIV;
      S_DIV: nxt = iter == 3'(DIV_ITERS - 1) ? S_STORE : S_DIV;
      S_STORE: nxt = last ? S_DONE : S_DIV;
      S_DONE: nxt = (pend || bus.tick_i || AUTO_SCAN) ? S_SNAP : S_IDLE;
      default: nxt = S_IDLE;
    endcase
    start = state == S_SNAP || (state == S_STORE && !last);
    idx = (state == S_STORE && !last) ? fld + 3'd1 : 3'd0;
    ovf = q > 4'd9;
    st_byte = ovf ? SAT_BCD : {q, r};
    wr = state == S_STORE && rdy;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  end
  // snapshot, field/iteration counters, shadow bank, pending request and published outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      fld <= '0;
      iter <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) snap[i] <= '0;
      shd <= '0;
      err_sh <= 1'b0;
      bcd <= '0;
      rerr <= 1'b0;
    end else begin
      pend <= (nxt == S_SNAP) ? 1'b0 : pend | (bus.tick_i && state != S_IDLE);
      if (nxt == S_SNAP) begin
        snap[F_SEC] <= {1'b0, bus.sec_ctr};
        snap[F_MIN] <= {1'b0, bus.min_ctr};
        snap[F_HRS] <= {2'b0, bus.hrs_ctr};
        snap[F_DAY] <= {2'b0, bus.day_o};
        snap[F_MON] <= {3'b0, bus.month_o};
        snap[F_YEAR] <= bus.year_o;
        snap[F_CEN] <= bus.cen_o;
      end
      iter <= state == S_DIV ? iter + 3'd1 : 3'd0;
      if (state == S_SNAP) fld <= '0;
      if (wr) begin
        fld <= fld + 3'd1;
        err_sh <= err_sh | ovf;
        if (!last) shd[{fld, 3'b000} +: 8] <= st_byte;
        if (last) begin
          bcd <= {st_byte, shd};
          rerr <= err_sh | ovf;
        end
      end
      if (state == S_DONE) err_sh <= 1'b0;
    end
  end
  assign bus.bcd_o = bcd;
  assign bus.range_err_o = rerr;
  assign bus.busy_o = state == S_SNAP || state == S_DIV || state == S_STORE;
  assign bus.done_o = state == S_DONE;
endmodule
